// File: rtl/seq_mult_16.sv
// Iterative unsigned 16x16 -> 32-bit shift-and-add multiplier with start/busy/done handshake.
// Each RUN cycle adds the multiplicand into the accumulator via one 16-bit carry-lookahead adder.

module cla_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  // Two-level lookahead: 4-bit groups, then a lookahead unit across the groups.
  always_comb begin
    g = a & b;
    p = a ^ b;
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < 4; j++) begin
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_p[j] = &p[4*j +: 4];
    end
  end

  always_comb begin
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
  end

  always_comb begin
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = grp_c[j];
      c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & grp_c[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & grp_c[j]);
    end
    sum  = p ^ c;
    cout = grp_c[4];
  end

endmodule

module seq_mult_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state;
  logic [15:0] m;
  logic [15:0] hi;
  logic [15:0] lo;
  logic [4:0]  count;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [31:0] shifted;

  assign add_b   = lo[0] ? m : 16'h0000;
  // Carry out becomes the new MSB, so the 33-bit partial sum never overflows.
  assign shifted = {add_cout, add_sum, lo[15:1]};

  cla_16_bit u_cla (
    .a    (hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            m     <= a;
            hi    <= '0;
            lo    <= b;
            count <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          {hi, lo} <= shifted;
          count    <= count + 5'd1;
          if (count == 5'd15) begin
            product <= shifted;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
